// File: rtl/ram4k_req_ctrl.sv
// Request/response front end for the 4K x 16 RAM: sequences read, write and block-fill
// commands onto the RAM pins and returns read data on a held response channel.
module ram4k_req_ctrl #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [DATA_W-1:0] ram_value,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StResp,
    StFill
  } state_e;

  localparam logic [1:0] OpRead  = 2'd0;
  localparam logic [1:0] OpWrite = 2'd1;
  localparam logic [1:0] OpFill  = 2'd2;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_ram_value;
  logic                r_ram_load;
  logic [ADDR_W-1:0]   r_ram_address;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                w_idle;

  assign w_idle      = (r_state == StIdle);
  assign req_ready   = w_idle;
  assign busy        = ~w_idle;
  assign ram_value   = r_ram_value;
  assign ram_load    = r_ram_load;
  assign ram_address = r_ram_address;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_ram_value   <= '0;
      r_ram_load    <= 1'b0;
      r_ram_address <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          // Reserved op is consumed here with no side effects.
          if (req_valid) begin
            case (req_op)
              OpRead: begin
                r_ram_address <= req_addr;
                r_state       <= StRead;
              end
              OpWrite: begin
                r_ram_address <= req_addr;
                r_ram_value   <= req_wdata;
                r_ram_load    <= 1'b1;
                r_state       <= StWrite;
              end
              OpFill: begin
                r_ram_address <= req_addr;
                r_ram_value   <= req_wdata;
                r_ram_load    <= 1'b1;
                r_cnt         <= req_len;
                r_state       <= StFill;
              end
              default: ;
            endcase
          end
        end
        StWrite: begin
          r_ram_load <= 1'b0;
          r_state    <= StIdle;
        end
        StRead: begin
          r_rsp_data  <= ram_out;
          r_rsp_valid <= 1'b1;
          r_state     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        StFill: begin
          // Address wraps naturally at 2**ADDR_W.
          if (r_cnt != '0) begin
            r_ram_address <= r_ram_address + ADDR_W'(1);
            r_cnt         <= r_cnt - ADDR_W'(1);
          end else begin
            r_ram_load <= 1'b0;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
